// File: rtl/regfile_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_port_arbiter_if
//   Bundles the two requester handshakes of the GPR port arbiter.
//   master : the requester side (decode read port + writeback write port)
//   slave  : the arbiter side
// Signals
//   rd_req / rd_addr           decode read request and index
//   rd_ack / rd_data           one-cycle read acknowledge and read result
//   wr_req / wr_addr / wr_data writeback request, index and value
//   wr_ack                     one-cycle write acknowledge (write committed)
//   busy                       arbiter is in the middle of an access
// -----------------------------------------------------------------------------
interface regfile_port_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_ack;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ack;
    logic                  busy;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data,
        input  rd_ack, rd_data, wr_ack, busy
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
        output rd_ack, rd_data, wr_ack, busy
    );
endinterface

// File: rtl/regfile_port_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_port_arbiter
//   Owns the general-purpose register storage and shares its single access
//   port between the decode stage (reads) and the writeback stage (writes).
//   Grants are round-robin; every access runs IDLE -> GRANT -> DONE, with the
//   owner's ack pulsed for the single DONE cycle. Register 0 reads as zero and
//   writes to it are dropped (but still acknowledged).
// Parameters
//   DATA_WIDTH  register width in bits
//   ADDR_WIDTH  register index width (2**ADDR_WIDTH entries)
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   bus            regfile_port_arbiter_if.slave (read/write handshakes, busy)
//   conflict_count 16-bit saturating count of simultaneous-request grants,
//                  present only when REGARB_STATS_EN is defined
// Configuration
//   REGARB_STATS_EN  enables the conflict_count statistics output
// -----------------------------------------------------------------------------
module regfile_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    regfile_port_arbiter_if.slave       bus
`ifdef REGARB_STATS_EN
    ,
    output logic [15:0]                 conflict_count
`endif
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        DONE
    } state_t;

    typedef enum logic {
        OWN_RD,
        OWN_WR
    } side_t;

    state_t                state;
    side_t                 owner;
    side_t                 last_grant;
    side_t                 grant_side;
    logic [DATA_WIDTH-1:0] gpr [DEPTH];

    // Side to grant if a request is present in IDLE. On a conflict the side
    // that did not win last time is chosen.
    always_comb begin
        grant_side = OWN_RD;
        if (bus.rd_req && bus.wr_req) begin
            if (last_grant == OWN_WR) begin
                grant_side = OWN_RD;
            end else begin
                grant_side = OWN_WR;
            end
        end else if (bus.wr_req) begin
            grant_side = OWN_WR;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            owner       <= OWN_RD;
            last_grant  <= OWN_WR;
            bus.rd_ack  <= 1'b0;
            bus.wr_ack  <= 1'b0;
            bus.rd_data <= '0;
            bus.busy    <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                gpr[i] <= '0;
            end
        end else begin
            bus.rd_ack <= 1'b0;
            bus.wr_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.rd_req || bus.wr_req) begin
                        owner      <= grant_side;
                        last_grant <= grant_side;
                        bus.busy   <= 1'b1;
                        state      <= GRANT;
                    end
                end
                GRANT: begin
                    // The access happens on the edge leaving GRANT, so the
                    // ack raised here lines up with the completed access.
                    if (owner == OWN_RD) begin
                        if (bus.rd_addr == '0) begin
                            bus.rd_data <= '0;
                        end else begin
                            bus.rd_data <= gpr[bus.rd_addr];
                        end
                        bus.rd_ack <= 1'b1;
                    end else begin
                        if (bus.wr_addr != '0) begin
                            gpr[bus.wr_addr] <= bus.wr_data;
                        end
                        bus.wr_ack <= 1'b1;
                    end
                    state <= DONE;
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

`ifdef REGARB_STATS_EN
    logic [15:0] conflict_q;

    // Every IDLE cycle with both requests high produces a grant, so the
    // conflict condition alone is enough to count it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conflict_q <= '0;
        end else if (state == IDLE && bus.rd_req && bus.wr_req && conflict_q != '1) begin
            conflict_q <= conflict_q + 16'd1;
        end
    end

    assign conflict_count = conflict_q;
`endif

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_port_arbiter
//   Directed self-checking bench for regfile_port_arbiter. Inputs are driven
//   between clock edges; outputs are sampled 1ns after the rising edge.
//   Build with REGARB_STATS_EN defined to include the statistics scenario.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_regfile_port_arbiter;

    logic clk;
    logic reset;
    int   asserts;
    int   fails;

    regfile_port_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

`ifdef REGARB_STATS_EN
    logic [15:0] conflict_count;
`endif

    regfile_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus)
`ifdef REGARB_STATS_EN
        ,
        .conflict_count (conflict_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus helpers: return observations only, callers do the checking.
    // edges = number of rising edges from raising req to seeing ack (-1 = timeout).
    task automatic do_write(input logic [4:0] a, input logic [31:0] d,
                            output int edges, output logic ack_next, output logic busy_next);
        @(negedge clk);
        bus.wr_addr = a;
        bus.wr_data = d;
        bus.wr_req  = 1'b1;
        edges = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (bus.wr_ack) begin
                edges = c;
                break;
            end
        end
        bus.wr_req = 1'b0;
        @(posedge clk); #1;
        ack_next  = bus.wr_ack;
        busy_next = bus.busy;
    endtask

    task automatic do_read(input logic [4:0] a, output logic [31:0] data,
                           output int edges, output logic ack_next);
        @(negedge clk);
        bus.rd_addr = a;
        bus.rd_req  = 1'b1;
        edges = -1;
        data  = 'x;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (bus.rd_ack) begin
                edges = c;
                data  = bus.rd_data;
                break;
            end
        end
        bus.rd_req = 1'b0;
        @(posedge clk); #1;
        ack_next = bus.rd_ack;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int          e;
        logic        an;
        int          bad;
        #1;
        asserts++;
        if (bus.rd_ack !== 1'b0 || bus.wr_ack !== 1'b0 || bus.busy !== 1'b0 || bus.rd_data !== 32'h0) begin
            fails++;
            $display("FAIL reset_outputs: rd_ack=%b wr_ack=%b busy=%b rd_data=%h, required all 0",
                     bus.rd_ack, bus.wr_ack, bus.busy, bus.rd_data);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (bus.rd_ack !== 1'b0 || bus.wr_ack !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        asserts++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL reset_idle_quiet: %0d cycles with ack/busy high, required 0", bad);
        end
        do_read(5'd5, d, e, an);
        asserts++;
        if (e !== 2) begin
            fails++;
            $display("FAIL reset_read5_latency: ack after %0d edges, required 2", e);
        end
        asserts++;
        if (d !== 32'h0) begin
            fails++;
            $display("FAIL reset_read5_data: got %h, required 00000000", d);
        end
    endtask

    task automatic test_write_read();
        logic [31:0] d;
        int          e;
        logic        an;
        logic        bn;
        // Ack lands on the third cycle of the request: request cycle, GRANT, DONE.
        do_write(5'd8, 32'hDEADBEEF, e, an, bn);
        asserts++;
        if (e !== 2) begin
            fails++;
            $display("FAIL wr8_latency: wr_ack after %0d edges, required 2", e);
        end
        asserts++;
        if (an !== 1'b0 || bn !== 1'b0) begin
            fails++;
            $display("FAIL wr8_ack_pulse: next cycle wr_ack=%b busy=%b, required 0 0", an, bn);
        end
        do_read(5'd8, d, e, an);
        asserts++;
        if (e !== 2 || d !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL rd8: edges=%0d data=%h, required 2 DEADBEEF", e, d);
        end
        asserts++;
        if (an !== 1'b0) begin
            fails++;
            $display("FAIL rd8_ack_pulse: next cycle rd_ack=%b, required 0", an);
        end
        do_write(5'd31, 32'h0F0F_1234, e, an, bn);
        do_read(5'd31, d, e, an);
        asserts++;
        if (d !== 32'h0F0F_1234) begin
            fails++;
            $display("FAIL rd31_top_index: got %h, required 0F0F1234", d);
        end
        do_read(5'd8, d, e, an);
        asserts++;
        if (d !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL rd8_unchanged: got %h, required DEADBEEF", d);
        end
    endtask

    task automatic test_write_zero();
        logic [31:0] d;
        int          e;
        logic        an;
        logic        bn;
        do_write(5'd0, 32'h0000_1234, e, an, bn);
        asserts++;
        if (e !== 2) begin
            fails++;
            $display("FAIL wr0_ack: wr_ack after %0d edges, required 2", e);
        end
        do_read(5'd0, d, e, an);
        asserts++;
        if (e !== 2 || d !== 32'h0) begin
            fails++;
            $display("FAIL rd0_zero: edges=%0d data=%h, required 2 00000000", e, d);
        end
    endtask

    // Both requesters held high from reset: reader reads idx 9 while writer
    // writes idx 9, so the reads see 0 then the written value.
    task automatic test_round_robin();
        int          order     [4];
        int          ack_edge  [4];
        logic [31:0] rdv       [2];
        int          exp_order [4] = '{0, 1, 0, 1};
        int          exp_edge  [4] = '{2, 5, 8, 11};
        int          n;
        int          nr;
        int          overlap;
        int          dbl;
        logic        prev_rd;
        logic        prev_wr;
        apply_reset();
        bus.rd_addr = 5'd9;
        bus.wr_addr = 5'd9;
        bus.wr_data = 32'h0000_A5A5;
        bus.rd_req  = 1'b1;
        bus.wr_req  = 1'b1;
        n = 0; nr = 0; overlap = 0; dbl = 0;
        prev_rd = 1'b0; prev_wr = 1'b0;
        for (int c = 1; c <= 40 && n < 4; c++) begin
            @(posedge clk); #1;
            if (bus.rd_ack && bus.wr_ack) overlap++;
            if ((bus.rd_ack && prev_rd) || (bus.wr_ack && prev_wr)) dbl++;
            if (bus.rd_ack) begin
                order[n] = 0; ack_edge[n] = c; n++;
                if (nr < 2) rdv[nr] = bus.rd_data;
                nr++;
            end else if (bus.wr_ack) begin
                order[n] = 1; ack_edge[n] = c; n++;
            end
            prev_rd = bus.rd_ack;
            prev_wr = bus.wr_ack;
        end
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b0;
        @(posedge clk); #1;
        asserts++;
        if (n !== 4) begin
            fails++;
            $display("FAIL rr_count: %0d acks seen, required 4", n);
        end else begin
            for (int i = 0; i < 4; i++) begin
                asserts++;
                if (order[i] !== exp_order[i] || ack_edge[i] !== exp_edge[i]) begin
                    fails++;
                    $display("FAIL rr_grant%0d: side=%0d edge=%0d, required side=%0d edge=%0d",
                             i, order[i], ack_edge[i], exp_order[i], exp_edge[i]);
                end
            end
            asserts++;
            if (rdv[0] !== 32'h0 || rdv[1] !== 32'h0000_A5A5) begin
                fails++;
                $display("FAIL rr_read_data: got %h %h, required 00000000 0000A5A5", rdv[0], rdv[1]);
            end
        end
        asserts++;
        if (overlap !== 0 || dbl !== 0) begin
            fails++;
            $display("FAIL rr_ack_pulses: overlap=%0d stretched=%0d, required 0 0", overlap, dbl);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] d;
        int          e;
        logic        an;
        int          seen;
        @(negedge clk);
        bus.wr_addr = 5'd3;
        bus.wr_data = 32'h55;
        bus.wr_req  = 1'b1;
        @(posedge clk); #1;
        asserts++;
        if (bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL abort_in_grant: busy=%b, required 1", bus.busy);
        end
        #2 reset = 1'b0;
        #1;
        asserts++;
        if (bus.busy !== 1'b0 || bus.wr_ack !== 1'b0) begin
            fails++;
            $display("FAIL abort_async_clear: busy=%b wr_ack=%b, required 0 0", bus.busy, bus.wr_ack);
        end
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (bus.wr_ack) seen++;
        end
        bus.wr_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (bus.wr_ack) seen++;
        end
        asserts++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL abort_no_ack: wr_ack seen %0d times, required 0", seen);
        end
        do_read(5'd3, d, e, an);
        asserts++;
        if (e !== 2 || d !== 32'h0) begin
            fails++;
            $display("FAIL abort_rd3: edges=%0d data=%h, required 2 00000000", e, d);
        end
    endtask

`ifdef REGARB_STATS_EN
    task automatic run_conflicts(input int grants);
        int n;
        @(negedge clk);
        bus.rd_req = 1'b1;
        bus.wr_req = 1'b1;
        n = 0;
        for (int c = 0; c < 200 && n < grants; c++) begin
            @(posedge clk); #1;
            if (bus.rd_ack || bus.wr_ack) n++;
        end
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_stats();
        apply_reset();
        #1;
        asserts++;
        if (conflict_count !== 16'd0) begin
            fails++;
            $display("FAIL stats_reset: got %0d, required 0", conflict_count);
        end
        run_conflicts(4);
        asserts++;
        if (conflict_count !== 16'd4) begin
            fails++;
            $display("FAIL stats_four: got %0d, required 4", conflict_count);
        end
        @(negedge clk);
        force dut.conflict_q = 16'hFFFE;
        @(negedge clk);
        release dut.conflict_q;
        run_conflicts(3);
        asserts++;
        if (conflict_count !== 16'hFFFF) begin
            fails++;
            $display("FAIL stats_saturate: got %h, required FFFF", conflict_count);
        end
    endtask
`endif

    initial begin
        asserts     = 0;
        fails       = 0;
        reset       = 1'b0;
        bus.rd_req  = 1'b0;
        bus.rd_addr = '0;
        bus.wr_req  = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        test_reset();
        test_write_read();
        test_write_zero();
        test_round_robin();
        test_reset_abort();
`ifdef REGARB_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
